// File: rtl/mem_arb_pkg.sv
// Shared types for the two-core data-port arbiter.
// Owner tags travel through the read tracker; core FSM states live in the top.
package mem_arb_pkg;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_C1,
        OWN_C2
    } owner_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_RD
    } core_st_t;

endpackage

// File: rtl/mem_rd_tracker.sv
// Delay line of read owners, aligned so the tag pops in the cycle
// that mem presents the matching read data.
module mem_rd_tracker
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  owner_t push_own,
    output owner_t pop_own
);

    localparam int DEPTH = (RD_LAT < 1) ? 1 :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    owner_t sr [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= OWN_NONE;
            end
        end else begin
            sr[0] <= push ? push_own : OWN_NONE;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign pop_own = sr[DEPTH-1];

endmodule

// File: rtl/mem_data_arbiter.sv
// Two-core data-port arbiter in front of a single-ported data memory.
// Round-robin grant, one access per cycle, read returns routed by owner.
module mem_data_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c1_ren,
    input  logic [ADDR_W-1:0] c1_raddr,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_rvalid,
    input  logic              c1_wen,
    input  logic [ADDR_W-1:0] c1_waddr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_stall,
    input  logic              c2_ren,
    input  logic [ADDR_W-1:0] c2_raddr,
    output logic [DATA_W-1:0] c2_rdata,
    output logic              c2_rvalid,
    input  logic              c2_wen,
    input  logic [ADDR_W-1:0] c2_waddr,
    input  logic [DATA_W-1:0] c2_wdata,
    output logic              c2_stall,
    output logic [ADDR_W-1:0] m_raddr,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [DATA_W-1:0] m_wdata
);

    core_st_t          st1, st2;
    logic              wd1, wd2;
    logic              rr_c2;
    logic [ADDR_W-1:0] raddr_q;
    owner_t            pop_own;
    owner_t            push_own;

    logic wr1, wr2;
    logic el1, el2;
    logic g1, g2;
    logic gw1, gw2;
    logic gr1, gr2;

    // wdN marks that the write half of a held ren+wen already went out
    assign wr1 = c1_wen & ~wd1;
    assign wr2 = c2_wen & ~wd2;

    assign el1 = ~reset & (st1 == ST_IDLE) & (c1_ren | wr1);
    assign el2 = ~reset & (st2 == ST_IDLE) & (c2_ren | wr2);

    assign g1 = el1 & (~el2 | ~rr_c2);
    assign g2 = el2 & (~el1 | rr_c2);

    assign gw1 = g1 & wr1;
    assign gw2 = g2 & wr2;
    assign gr1 = g1 & ~wr1;
    assign gr2 = g2 & ~wr2;

    assign m_wen   = gw1 | gw2;
    assign m_waddr = gw2 ? c2_waddr : (gw1 ? c1_waddr : '0);
    assign m_wdata = gw2 ? c2_wdata : (gw1 ? c1_wdata : '0);
    assign m_raddr = gr2 ? c2_raddr : (gr1 ? c1_raddr : raddr_q);

    assign push_own = gr2 ? OWN_C2 : OWN_C1;

    assign c1_stall = ~reset & (c1_ren | c1_wen)
                    & ~((gw1 & ~c1_ren) | c1_rvalid);
    assign c2_stall = ~reset & (c2_ren | c2_wen)
                    & ~((gw2 & ~c2_ren) | c2_rvalid);

    mem_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_trk (
        .clk      (clk),
        .reset    (reset),
        .push     (gr1 | gr2),
        .push_own (push_own),
        .pop_own  (pop_own)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st1     <= ST_IDLE;
            st2     <= ST_IDLE;
            wd1     <= 1'b0;
            wd2     <= 1'b0;
            rr_c2   <= 1'b0;
            raddr_q <= '0;
        end else begin
            raddr_q <= m_raddr;
            if (g1 | g2) begin
                rr_c2 <= ~rr_c2;
            end
            case (st1)
                ST_IDLE:    if (gr1) st1 <= ST_WAIT_RD;
                ST_WAIT_RD: if (c1_rvalid) st1 <= ST_IDLE;
            endcase
            case (st2)
                ST_IDLE:    if (gr2) st2 <= ST_WAIT_RD;
                ST_WAIT_RD: if (c2_rvalid) st2 <= ST_IDLE;
            endcase
            if (gw1 & c1_ren) begin
                wd1 <= 1'b1;
            end else if (gr1) begin
                wd1 <= 1'b0;
            end
            if (gw2 & c2_ren) begin
                wd2 <= 1'b1;
            end else if (gr2) begin
                wd2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c1_rvalid <= 1'b0;
            c2_rvalid <= 1'b0;
            c1_rdata  <= '0;
            c2_rdata  <= '0;
        end else begin
            c1_rvalid <= (pop_own == OWN_C1);
            c2_rvalid <= (pop_own == OWN_C2);
            if (pop_own == OWN_C1) begin
                c1_rdata <= m_rdata;
            end
            if (pop_own == OWN_C2) begin
                c2_rdata <= m_rdata;
            end
        end
    end

endmodule
